// File: rtl/hdr_in_buf_pkg.sv
// rtl/hdr_in_buf_pkg.sv - shared widths and header entry type for the ingress header buffer
package hdr_in_buf_pkg;

  localparam int BYTE_W      = 8;
  localparam int DATA_W      = 8;
  localparam int HDR_MAX_LEN = 16;
  localparam int HDR_IDX_W   = $clog2(HDR_MAX_LEN);

  typedef logic [BYTE_W-1:0] byte_t;
  typedef byte_t [HDR_MAX_LEN-1:0] hdr_bytes_t;

  typedef struct packed {
    hdr_bytes_t          hdr;
    logic [DATA_W-1:0]   len;
  } hdr_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DROP    = 2'd2
  } asm_state_t;

endpackage

// File: rtl/hdr_in_buf_if.sv
// rtl/hdr_in_buf_if.sv - ingress byte stream and header read port bundle
interface hdr_in_buf_if;
  import hdr_in_buf_pkg::*;

  logic              in_valid_i;
  logic              in_sop_i;
  logic              in_eop_i;
  byte_t             in_data_i;
  logic              in_ready_o;
  logic              hdr_empty_o;
  logic              hdr_rd_i;
  hdr_bytes_t        pkt_hdr_o;
  logic [DATA_W-1:0] hdr_len_o;

  modport slave (
    input  in_valid_i, in_sop_i, in_eop_i, in_data_i, hdr_rd_i,
    output in_ready_o, hdr_empty_o, pkt_hdr_o, hdr_len_o
  );

  modport master (
    output in_valid_i, in_sop_i, in_eop_i, in_data_i, hdr_rd_i,
    input  in_ready_o, hdr_empty_o, pkt_hdr_o, hdr_len_o
  );

endinterface

// File: rtl/hdr_in_buf_fifo_fwft.sv
// rtl/hdr_in_buf_fifo_fwft.sv - first-word-fall-through FIFO of header entries
module hdr_fifo_fwft
  import hdr_in_buf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  hdr_entry_t               i_entry,
  input  logic                     i_pop,
  output hdr_entry_t               o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  hdr_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;

  // Writers upstream hold a reservation, so a push never finds the FIFO full.
  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (i_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!i_push && w_pop) r_count <= r_count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_entry;
  end

  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/hdr_in_buf.sv
// rtl/hdr_in_buf.sv - captures the leading bytes of each packet and queues them as headers
module hdr_in_buf
  import hdr_in_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  hdr_in_buf_if.slave       bus,
  output logic [CNT_W-1:0]  drop_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]        RESV_ONE  = 1;
  localparam logic [AW+1:0]      DEPTH_C   = (AW+2)'(DEPTH);
  localparam logic [DATA_W-1:0]  MAX_LEN_C = DATA_W'(HDR_MAX_LEN);
  localparam logic [DATA_W-1:0]  LEN_ONE   = 1;
  localparam logic [CNT_W-1:0]   CNT_INC   = 1;

  asm_state_t        r_state, w_state_n;
  hdr_bytes_t        r_buf, w_buf_n, w_buf_wr;
  logic [DATA_W-1:0] r_len, w_len_n, w_len_sat;
  logic [AW:0]       r_resv, w_resv_n;
  logic              r_ready;
  logic [CNT_W-1:0]  r_drop_cnt, r_err_cnt;

  logic              w_acc, w_sop_idle, w_free;
  logic              w_push, w_drop_inc, w_err_inc;
  hdr_entry_t        w_push_entry, w_head;
  logic [AW:0]       w_count;
  logic              w_empty;
  logic [AW+1:0]     w_used;

  assign w_acc = bus.in_valid_i && r_ready;

  always_comb begin
    w_buf_wr = r_buf;
    if (r_len < MAX_LEN_C) w_buf_wr[r_len[HDR_IDX_W-1:0]] = bus.in_data_i;
  end
  assign w_len_sat = (r_len < MAX_LEN_C) ? r_len + LEN_ONE : r_len;

  always_comb begin
    w_state_n    = r_state;
    w_buf_n      = r_buf;
    w_len_n      = r_len;
    w_resv_n     = r_resv;
    w_push       = 1'b0;
    w_push_entry = '0;
    w_drop_inc   = 1'b0;
    w_err_inc    = 1'b0;
    w_sop_idle   = 1'b0;
    w_used       = '0;
    w_free       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_acc && bus.in_sop_i) w_sop_idle = 1'b1;
      end
      ST_COLLECT: begin
        if (w_acc) begin
          if (bus.in_sop_i) begin
            // Abort: release the slot, then treat this beat as a fresh SOP.
            w_err_inc  = 1'b1;
            w_resv_n   = '0;
            w_sop_idle = 1'b1;
          end else begin
            w_buf_n = w_buf_wr;
            w_len_n = w_len_sat;
            if (bus.in_eop_i) begin
              w_push       = 1'b1;
              w_push_entry = '{hdr: w_buf_wr, len: w_len_sat};
              w_resv_n     = '0;
              w_state_n    = ST_IDLE;
            end
          end
        end
      end
      ST_DROP: begin
        if (w_acc) begin
          if (bus.in_sop_i)      w_sop_idle = 1'b1;
          else if (bus.in_eop_i) w_state_n  = ST_IDLE;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase

    if (w_sop_idle) begin
      w_used = {1'b0, w_count} + {1'b0, w_resv_n};
      w_free = (w_used < DEPTH_C);
      if (w_free) begin
        if (bus.in_eop_i) begin
          w_push       = 1'b1;
          w_push_entry = '0;
          w_push_entry.hdr[0] = bus.in_data_i;
          w_push_entry.len    = LEN_ONE;
          w_state_n    = ST_IDLE;
        end else begin
          w_resv_n   = RESV_ONE;
          w_buf_n    = '0;
          w_buf_n[0] = bus.in_data_i;
          w_len_n    = LEN_ONE;
          w_state_n  = ST_COLLECT;
        end
      end else begin
        w_drop_inc = 1'b1;
        w_state_n  = bus.in_eop_i ? ST_IDLE : ST_DROP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_buf      <= '0;
      r_len      <= '0;
      r_resv     <= '0;
      r_ready    <= 1'b0;
      r_drop_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_state <= w_state_n;
      r_buf   <= w_buf_n;
      r_len   <= w_len_n;
      r_resv  <= w_resv_n;
      r_ready <= 1'b1;
      if (w_drop_inc) r_drop_cnt <= r_drop_cnt + CNT_INC;
      if (w_err_inc)  r_err_cnt  <= r_err_cnt + CNT_INC;
    end
  end

  hdr_fifo_fwft #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_push_entry),
    .i_pop   (bus.hdr_rd_i),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign bus.in_ready_o  = r_ready;
  assign bus.hdr_empty_o = w_empty;
  assign bus.pkt_hdr_o   = w_head.hdr;
  assign bus.hdr_len_o   = w_head.len;
  assign drop_cnt_o      = r_drop_cnt;
  assign err_cnt_o       = r_err_cnt;

endmodule

// File: tb/tb_hdr_in_buf.sv
// tb/tb_hdr_in_buf.sv - scoreboard bench for hdr_in_buf
module tb_hdr_in_buf;
  import hdr_in_buf_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CNT_W-1:0] drop_cnt, err_cnt;

  hdr_in_buf_if ifc ();

  hdr_in_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (ifc.slave),
    .drop_cnt_o (drop_cnt),
    .err_cnt_o  (err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  hdr_entry_t exp_q[$];
  hdr_entry_t mon_e;
  hdr_entry_t e;

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares the head entry on every accepted pop.
  always @(negedge clk) begin
    if (!rst && ifc.hdr_rd_i && !ifc.hdr_empty_o) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL pop_unexpected: got len %0h, expected no entry", ifc.hdr_len_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_hdr", 160'(ifc.pkt_hdr_o), 160'(mon_e.hdr));
        check("pop_len", 160'(ifc.hdr_len_o), 160'(mon_e.len));
      end
    end
  end

  task automatic beat(input logic sop, input logic eop, input byte_t d);
    ifc.in_valid_i = 1'b1;
    ifc.in_sop_i   = sop;
    ifc.in_eop_i   = eop;
    ifc.in_data_i  = d;
    @(posedge clk); #1;
    ifc.in_valid_i = 1'b0;
    ifc.in_sop_i   = 1'b0;
    ifc.in_eop_i   = 1'b0;
  endtask

  task automatic pop();
    ifc.hdr_rd_i = 1'b1;
    @(posedge clk); #1;
    ifc.hdr_rd_i = 1'b0;
  endtask

  task automatic exp_one(input byte_t d);
    hdr_entry_t x;
    x = '0;
    x.hdr[0] = d;
    x.len = 8'd1;
    exp_q.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.in_valid_i = 1'b0;
    ifc.in_sop_i   = 1'b0;
    ifc.in_eop_i   = 1'b0;
    ifc.in_data_i  = '0;
    ifc.hdr_rd_i   = 1'b0;
    #12;
    check("rst_ready", 160'(ifc.in_ready_o), 160'(0));
    check("rst_empty", 160'(ifc.hdr_empty_o), 160'(1));
    check("rst_hdr",   160'(ifc.pkt_hdr_o), 160'(0));
    check("rst_len",   160'(ifc.hdr_len_o), 160'(0));
    check("rst_drop",  160'(drop_cnt), 160'(0));
    check("rst_err",   160'(err_cnt), 160'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("ready_up", 160'(ifc.in_ready_o), 160'(1));

    // 3-byte packet
    e = '0; e.hdr[0] = 8'h11; e.hdr[1] = 8'h22; e.hdr[2] = 8'h33; e.len = 8'd3;
    exp_q.push_back(e);
    beat(1, 0, 8'h11); beat(0, 0, 8'h22);
    check("empty_before_eop", 160'(ifc.hdr_empty_o), 160'(1));
    beat(0, 1, 8'h33);
    check("empty_after_eop", 160'(ifc.hdr_empty_o), 160'(0));
    check("len_3", 160'(ifc.hdr_len_o), 160'(3));
    pop();
    check("empty_after_pop", 160'(ifc.hdr_empty_o), 160'(1));
    check("hdr_zero_empty", 160'(ifc.pkt_hdr_o), 160'(0));

    // Long packet, truncated at HDR_MAX_LEN
    e = '0;
    for (int i = 0; i < HDR_MAX_LEN; i++) e.hdr[i] = byte_t'(i);
    e.len = 8'(HDR_MAX_LEN);
    exp_q.push_back(e);
    for (int i = 0; i < HDR_MAX_LEN + 10; i++)
      beat(i == 0, i == HDR_MAX_LEN + 9, byte_t'(i));
    check("long_len", 160'(ifc.hdr_len_o), 160'(HDR_MAX_LEN));
    pop();

    // DEPTH+2 single-byte packets, no reads
    for (int k = 0; k < DEPTH + 2; k++) begin
      if (k < DEPTH) exp_one(byte_t'(8'h40 + k));
      beat(1, 1, byte_t'(8'h40 + k));
    end
    check("drop_cnt_2", 160'(drop_cnt), 160'(2));
    check("err_cnt_0",  160'(err_cnt), 160'(0));
    for (int k = 0; k < DEPTH; k++) pop();
    check("drained_empty", 160'(ifc.hdr_empty_o), 160'(1));

    // Abort by new SOP
    exp_one(8'hCC);
    beat(1, 0, 8'hAA); beat(0, 0, 8'hBB); beat(1, 1, 8'hCC);
    check("err_cnt_1",    160'(err_cnt), 160'(1));
    check("abort_len",    160'(ifc.hdr_len_o), 160'(1));
    pop();
    check("abort_single", 160'(ifc.hdr_empty_o), 160'(1));

    // Simultaneous push and pop with 3 entries held
    exp_one(8'h51); exp_one(8'h52); exp_one(8'h53);
    beat(1, 1, 8'h51); beat(1, 1, 8'h52); beat(1, 1, 8'h53);
    e = '0; e.hdr[0] = 8'h61; e.hdr[1] = 8'h62; e.len = 8'd2;
    exp_q.push_back(e);
    beat(1, 0, 8'h61);
    ifc.hdr_rd_i = 1'b1;
    beat(0, 1, 8'h62);
    ifc.hdr_rd_i = 1'b0;
    pop(); pop();
    check("one_left", 160'(ifc.hdr_empty_o), 160'(0));
    pop();
    check("pushpop_empty", 160'(ifc.hdr_empty_o), 160'(1));
    pop();
    check("rd_empty_stays", 160'(ifc.hdr_empty_o), 160'(1));
    check("rd_empty_len",   160'(ifc.hdr_len_o), 160'(0));
    check("drop_unchanged", 160'(drop_cnt), 160'(2));

    // Reset mid-COLLECT with two headers queued
    exp_one(8'h71); exp_one(8'h72);
    beat(1, 1, 8'h71); beat(1, 1, 8'h72);
    beat(1, 0, 8'h81); beat(0, 0, 8'h82);
    check("queued_before_rst", 160'(ifc.hdr_empty_o), 160'(0));
    rst = 1'b1;
    #1;
    check("rst_mid_empty", 160'(ifc.hdr_empty_o), 160'(1));
    check("rst_mid_ready", 160'(ifc.in_ready_o), 160'(0));
    check("rst_mid_err",   160'(err_cnt), 160'(0));
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    e = '0; e.hdr[0] = 8'h91; e.hdr[1] = 8'h92; e.hdr[2] = 8'h93; e.hdr[3] = 8'h94; e.len = 8'd4;
    exp_q.push_back(e);
    beat(1, 0, 8'h91); beat(0, 0, 8'h92); beat(0, 0, 8'h93); beat(0, 1, 8'h94);
    check("fresh_len", 160'(ifc.hdr_len_o), 160'(4));
    pop();
    check("final_empty", 160'(ifc.hdr_empty_o), 160'(1));
    check("scoreboard_drained", 160'(exp_q.size()), 160'(0));

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
